// File: rtl/fifo_sync_thresh_pkg.sv
// Shared constants and helpers for the thresholded synchronous FIFO:
// depth derivation and the reset values of the read port and error flags.
package fifo_pkg;

    function automatic int fifo_depth(input int index_width);
        return 1 << index_width;
    endfunction

    localparam logic RD_DATA_RST_BIT = 1'b0;
    localparam logic RD_VALID_RST    = 1'b0;
    localparam logic OVERFLOW_RST    = 1'b0;
    localparam logic UNDERFLOW_RST   = 1'b0;

endpackage

// File: rtl/fifo_sync_thresh_if.sv
// Stream/status bundle between a producer-consumer pair and fifo_sync_thresh.
// err_clr/overflow/underflow exist only when FIFO_ERR_FLAGS_EN is defined.
interface fifo_sync_thresh_if #(
    parameter int DATA_WIDTH  = 8,
    parameter int INDEX_WIDTH = 2
);
    logic                   wr_en;
    logic [DATA_WIDTH-1:0]  wr_data;
    logic                   rd_en;
    logic [DATA_WIDTH-1:0]  rd_data;
    logic                   rd_valid;
    logic                   full;
    logic                   empty;
    logic [INDEX_WIDTH:0]   count;
    logic [INDEX_WIDTH:0]   af_thresh;
    logic [INDEX_WIDTH:0]   ae_thresh;
    logic                   almost_full;
    logic                   almost_empty;
`ifdef FIFO_ERR_FLAGS_EN
    logic                   err_clr;
    logic                   overflow;
    logic                   underflow;

    modport master (
        output wr_en, wr_data, rd_en, af_thresh, ae_thresh, err_clr,
        input  rd_data, rd_valid, full, empty, count, almost_full, almost_empty,
               overflow, underflow
    );
    modport slave (
        input  wr_en, wr_data, rd_en, af_thresh, ae_thresh, err_clr,
        output rd_data, rd_valid, full, empty, count, almost_full, almost_empty,
               overflow, underflow
    );
`else
    modport master (
        output wr_en, wr_data, rd_en, af_thresh, ae_thresh,
        input  rd_data, rd_valid, full, empty, count, almost_full, almost_empty
    );
    modport slave (
        input  wr_en, wr_data, rd_en, af_thresh, ae_thresh,
        output rd_data, rd_valid, full, empty, count, almost_full, almost_empty
    );
`endif
endinterface

// File: rtl/fifo_sync_thresh_mem.sv
// Register-file storage for the FIFO: one write port, one registered read port.
// Contents and read register are deliberately unreset.
module fifo_mem
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH  = 8,
    parameter int INDEX_WIDTH = 2
) (
    input  logic                   clk,
    input  logic                   wr_en,
    input  logic [INDEX_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0]  wr_data,
    input  logic                   rd_en,
    input  logic [INDEX_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0]  rd_data
);
    localparam int DEPTH = fifo_depth(INDEX_WIDTH);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // A same-edge write to rd_addr still returns the old entry (read-before-write)
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/fifo_sync_thresh.sv
// Synchronous FIFO with registered occupancy, almost-full/empty thresholds and
// registered read data. Define FIFO_ERR_FLAGS_EN for sticky overflow/underflow.
module fifo_sync_thresh
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH  = 8,
    parameter int INDEX_WIDTH = 2
) (
    input  logic              clk,
    input  logic              rst,
    fifo_sync_thresh_if.slave bus
);
    localparam int PTR_WIDTH = INDEX_WIDTH + 1;
    localparam logic [PTR_WIDTH-1:0] DEPTH_P = PTR_WIDTH'(fifo_depth(INDEX_WIDTH));

    logic [PTR_WIDTH-1:0]  wr_ptr;
    logic [PTR_WIDTH-1:0]  rd_ptr;
    logic [PTR_WIDTH-1:0]  count_q;
    logic [PTR_WIDTH-1:0]  wr_ptr_next;
    logic [PTR_WIDTH-1:0]  rd_ptr_next;
    logic                  full;
    logic                  empty;
    logic                  wr_acc;
    logic                  rd_acc;
    logic                  rd_vld_p1;
    logic                  rd_loaded_p1;
    logic [DATA_WIDTH-1:0] mem_rd_data_p1;

    assign full  = (count_q == DEPTH_P);
    assign empty = (count_q == '0);

    // A full FIFO may still take a write when a read frees a slot on the same edge
    assign wr_acc = bus.wr_en && (!full || bus.rd_en);
    assign rd_acc = bus.rd_en && !empty;

    always_comb begin
        wr_ptr_next = wr_ptr;
        rd_ptr_next = rd_ptr;
        if (wr_acc) begin
            wr_ptr_next = wr_ptr + PTR_WIDTH'(1);
        end
        if (rd_acc) begin
            rd_ptr_next = rd_ptr + PTR_WIDTH'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count_q      <= '0;
            rd_vld_p1    <= RD_VALID_RST;
            rd_loaded_p1 <= 1'b0;
        end else begin
            wr_ptr    <= wr_ptr_next;
            rd_ptr    <= rd_ptr_next;
            count_q   <= wr_ptr_next - rd_ptr_next;
            rd_vld_p1 <= rd_acc;
            if (rd_acc) begin
                rd_loaded_p1 <= 1'b1;
            end
        end
    end

    // ---- stage p1: registered read port ----
    fifo_mem #(
        .DATA_WIDTH  (DATA_WIDTH),
        .INDEX_WIDTH (INDEX_WIDTH)
    ) u_mem (
        .clk     (clk),
        .wr_en   (wr_acc),
        .wr_addr (wr_ptr[INDEX_WIDTH-1:0]),
        .wr_data (bus.wr_data),
        .rd_en   (rd_acc),
        .rd_addr (rd_ptr[INDEX_WIDTH-1:0]),
        .rd_data (mem_rd_data_p1)
    );

    // Storage has no reset, so the reset value of rd_data is imposed here until the first pop
    assign bus.rd_data  = rd_loaded_p1 ? mem_rd_data_p1 : {DATA_WIDTH{RD_DATA_RST_BIT}};
    assign bus.rd_valid = rd_vld_p1;

    assign bus.full         = full;
    assign bus.empty        = empty;
    assign bus.count        = count_q;
    assign bus.almost_full  = (count_q >= bus.af_thresh);
    assign bus.almost_empty = (count_q <= bus.ae_thresh);

`ifdef FIFO_ERR_FLAGS_EN
    logic overflow_q;
    logic underflow_q;

    // A fresh error in the clearing cycle takes priority over err_clr
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overflow_q  <= OVERFLOW_RST;
            underflow_q <= UNDERFLOW_RST;
        end else begin
            if (bus.wr_en && !wr_acc) begin
                overflow_q <= 1'b1;
            end else if (bus.err_clr) begin
                overflow_q <= 1'b0;
            end
            if (bus.rd_en && empty) begin
                underflow_q <= 1'b1;
            end else if (bus.err_clr) begin
                underflow_q <= 1'b0;
            end
        end
    end

    assign bus.overflow  = overflow_q;
    assign bus.underflow = underflow_q;
`endif

endmodule

// File: doc/fifo_sync_thresh.md
# fifo_sync_thresh

Parametrised synchronous FIFO; the next generation of the team's Tiny Tapeout FIFO core. Generalises data width and depth, adds live occupancy count, programmable almost-full/almost-empty thresholds, registered read data with a valid strobe, and optional sticky overflow/underflow flags. Sits between the `ui_in`/`uio_in` pin decode and the `uo_out` driver inside the top-level `tt_um_` wrapper; it can also be reused standalone as a stream buffer.

## Interface
- `DATA_WIDTH`, default 8: width of one entry.
- `INDEX_WIDTH`, default 2: address bits; depth `DEPTH = 1 << INDEX_WIDTH`.
- `clk`  in  1  single clock; all state changes on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `wr_en`  in  1  write request.
- `wr_data`  in  DATA_WIDTH  write data, sampled when the write is accepted.
- `rd_en`  in  1  read request.
- `rd_data`  out  DATA_WIDTH  registered read data.
- `rd_valid`  out  1  one-cycle pulse: `rd_data` holds a newly popped entry.
- `full`  out  1  `count == DEPTH`.
- `empty`  out  1  `count == 0`.
- `count`  out  INDEX_WIDTH+1  current occupancy, 0..DEPTH.
- `af_thresh`  in  INDEX_WIDTH+1  almost-full threshold.
- `ae_thresh`  in  INDEX_WIDTH+1  almost-empty threshold.
- `almost_full`  out  1  `count >= af_thresh`.
- `almost_empty`  out  1  `count <= ae_thresh`.
- `err_clr`  in  1  clears sticky error flags. Present only with `FIFO_ERR_FLAGS_EN`.
- `overflow`  out  1  sticky flag: a write was rejected. Present only with `FIFO_ERR_FLAGS_EN`.
- `underflow`  out  1  sticky flag: a read was rejected. Present only with `FIFO_ERR_FLAGS_EN`.

## Operation
- Pointers: `wr_ptr` and `rd_ptr`, each INDEX_WIDTH+1 bits.
  - Low INDEX_WIDTH bits address storage. The MSB is the wrap bit.
  - `count = wr_ptr - rd_ptr`, computed modulo 2^(INDEX_WIDTH+1). The count is held in a register, not derived combinationally.
- Write accept: `wr_en && (!full || rd_en)`.
  - On accept, `mem[wr_ptr[INDEX_WIDTH-1:0]] <= wr_data` and `wr_ptr` increments.
- Read accept: `rd_en && !empty`.
  - On accept, `rd_data <= mem[rd_ptr[INDEX_WIDTH-1:0]]`, `rd_valid <= 1`, and `rd_ptr` increments.
  - Otherwise `rd_valid <= 0` and `rd_data` holds its previous value.
- Simultaneous read and write:
  - When full: both are accepted and `count` is unchanged.
  - When empty: only the write is accepted. There is no bypass; the read is rejected.
- Pointer wrap-around is natural binary overflow; no special case is needed.
- Thresholds are compared combinationally against the registered `count`.
  - `af_thresh = 0` makes `almost_full` always 1.
  - `ae_thresh >= DEPTH` makes `almost_empty` always 1.
- Reset values:
  - Pointers, `count`, `rd_data`, `rd_valid` are 0.
  - `empty = 1`, `full = 0`, `almost_empty = 1`.
  - `almost_full = (af_thresh == 0)`.
  - `overflow = underflow = 0`.
  - Storage is not reset.
- Reset asserted mid-operation clears all state immediately (asynchronously). Entries in flight are discarded.

## Timing
- Write-to-read latency: data written at edge N can be read-accepted at edge N+1. It appears on `rd_data` after that edge.
- Read latency: 1 cycle from the accepting edge to `rd_data`/`rd_valid`.
- `full`, `empty`, `count`, and both almost flags update on the same edge as the accepted operation.
- No combinational path exists from `wr_en`/`rd_en` to any output.

## Configuration
- `FIFO_ERR_FLAGS_EN` defined:
  - `overflow` sets on any cycle with `wr_en` and the write not accepted.
  - `underflow` sets on any cycle with `rd_en && empty`.
  - Both flags clear on `err_clr`. If `err_clr` and a new error occur in the same cycle, set wins.
- Undefined: `err_clr`, `overflow` and `underflow` ports and their logic are absent. Rejected requests are silently dropped.

## Structure
- Package `fifo_pkg` holds:
  - constant function `fifo_depth(index_width)`;
  - the reset-value constants for `rd_data` and the flags.
- Sub-module `fifo_mem`: register-file storage with one write port and one registered read port, parametrised by `DATA_WIDTH` and `INDEX_WIDTH`. No reset.
- The control logic (pointers, count, flags) lives in `fifo_sync_thresh`.

## Test plan
- Reset, then 4 writes of 0x11, 0x22, 0x33, 0x44 with DEPTH=4 -> `count` 1,2,3,4; `full=1` after the 4th; 4 reads -> `rd_data` 0x11..0x44, each with a one-cycle `rd_valid`; `empty=1` at the end.
- Full FIFO, write 0x55 with `rd_en=0` -> contents unchanged, `count=4`, `overflow=1` (with `FIFO_ERR_FLAGS_EN`); `err_clr` -> `overflow=0`.
- Full FIFO, `wr_en` and `rd_en` together with 0x66 -> oldest entry read out, `count` stays 4, 0x66 read out last.
- Empty FIFO, `wr_en` and `rd_en` together with 0x77 -> `rd_valid=0`, `count=1`, `underflow=1`; next read returns 0x77.
- `af_thresh=3`, `ae_thresh=1`; write 3 entries -> `almost_empty` drops at `count=2`, `almost_full` rises at `count=3`.
- 10 write/read pairs with wrapping pointers, then assert `rst` mid-stream between edges -> all outputs at reset values immediately, before the next clock edge.
